// File: rtl/mem_pkg.sv
// Shared types for the memory responder: FSM states, strobe constants and the request bundle.
// The optional MEM_FAULT_EN build uses is_full_word() for alignment faults.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_state_t;

   localparam logic [3:0] WSTRB_NONE = 4'b0000;
   localparam logic [3:0] WSTRB_WORD = 4'b1111;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic        instr;
   } mem_req_t;

   // Any fetch is treated as a whole-word access for alignment purposes.
   function automatic logic is_full_word(input mem_req_t req);
      return (req.wstrb == WSTRB_WORD) || req.instr;
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Ready/valid memory port between an initiator (master) and the RAM responder (slave).
// mem_fault exists only when MEM_FAULT_EN is defined.
interface mem_responder_if;

   logic        mem_ready;
   logic        mem_instr;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_valid;
   logic [31:0] mem_rdata;
`ifdef MEM_FAULT_EN
   logic        mem_fault;

   modport master (
      output mem_ready, mem_instr, mem_addr, mem_wstrb, mem_wdata,
      input  mem_valid, mem_rdata, mem_fault
   );

   modport slave (
      input  mem_ready, mem_instr, mem_addr, mem_wstrb, mem_wdata,
      output mem_valid, mem_rdata, mem_fault
   );
`else
   modport master (
      output mem_ready, mem_instr, mem_addr, mem_wstrb, mem_wdata,
      input  mem_valid, mem_rdata
   );

   modport slave (
      input  mem_ready, mem_instr, mem_addr, mem_wstrb, mem_wdata,
      output mem_valid, mem_rdata
   );
`endif

endinterface

// File: rtl/mem_bytelane_ram.sv
// DEPTH x 32 RAM built from four byte-wide lanes, each with its own write enable.
// Read is registered and returns the pre-write contents (read-first).
module mem_bytelane_ram #(
   parameter  int DEPTH = 1024,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          en_i,
   input  logic [3:0]    we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem_q [DEPTH];
         logic [7:0] lane_rd_q;

         always_ff @(posedge clk) begin
            if (en_i) begin
               if (we_i[gi]) begin
                  lane_mem_q[addr_i] <= wdata_i[gi*8 +: 8];
               end
               lane_rd_q <= lane_mem_q[addr_i];
            end
         end

         assign rdata_o[gi*8 +: 8] = lane_rd_q;
      end
   endgenerate

endmodule

// File: rtl/mem_responder.sv
// Word-organised RAM answering ready/valid requests after LATENCY cycles.
// Optional feature: define MEM_FAULT_EN to add the mem_fault error response.
module mem_responder
   import mem_pkg::*;
#(
   parameter int          DEPTH     = 1024,
   parameter int          LATENCY   = 1,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic           clk,
   input  logic           reset,
   mem_responder_if.slave mem_if
);

   localparam int AW = $clog2(DEPTH);

   mem_state_t  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        hit_q, hit_d;

   mem_req_t    req;
   logic [29:0] word_off;
   logic        below_base;
   logic        in_range;
   logic        req_fault;
   logic        accept;
   logic [3:0]  ram_we;
   logic [31:0] ram_rdata;

   assign req = '{addr:  mem_if.mem_addr,
                  wstrb: mem_if.mem_wstrb,
                  wdata: mem_if.mem_wdata,
                  instr: mem_if.mem_instr};

   // BASE_ADDR is DEPTH*4 aligned, so the word offset alone decides the range.
   assign below_base = req.addr < BASE_ADDR;
   assign word_off   = req.addr[31:2] - BASE_ADDR[31:2];
   assign in_range   = !below_base && (word_off[29:AW] == '0);

`ifdef MEM_FAULT_EN
   logic fault_q, fault_d;

   assign req_fault = !in_range
                    || ((req.addr[1:0] != 2'b00) && is_full_word(req))
                    || (req.instr && (req.wstrb != WSTRB_NONE));
`else
   logic unused_addr_lsbs;

   assign req_fault        = !in_range;
   assign unused_addr_lsbs = ^req.addr[1:0];
`endif

   assign accept = (state_q == IDLE) && mem_if.mem_ready && !reset;
   assign ram_we = (accept && !req_fault && !req.instr) ? req.wstrb : WSTRB_NONE;

   mem_bytelane_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .en_i    (accept),
      .we_i    (ram_we),
      .addr_i  (word_off[AW-1:0]),
      .wdata_i (req.wdata),
      .rdata_o (ram_rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hit_d   = hit_q;
`ifdef MEM_FAULT_EN
      fault_d = fault_q;
`endif
      case (state_q)
         IDLE: begin
            if (mem_if.mem_ready) begin
               hit_d = in_range;
`ifdef MEM_FAULT_EN
               fault_d = req_fault;
`endif
               if (LATENCY == 1) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 4'(LATENCY - 2);
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Array contents are deliberately untouched by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         hit_q   <= 1'b0;
`ifdef MEM_FAULT_EN
         fault_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hit_q   <= hit_d;
`ifdef MEM_FAULT_EN
         fault_q <= fault_d;
`endif
      end
   end

   // Gating with reset keeps an aborted response from ever pulsing.
   assign mem_if.mem_valid = (state_q == RESP) && !reset;
   assign mem_if.mem_rdata = hit_q ? ram_rdata : 32'h0;
`ifdef MEM_FAULT_EN
   assign mem_if.mem_fault = fault_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances (LATENCY 1, 3, 4) driven in turn.
// Expected responses come from a small word model and are compared as the DUT answers.
module tb_mem_responder;
   import mem_pkg::*;

   localparam int          NW       = 64;
   localparam int          LAT  [3] = '{1, 3, 4};
   localparam logic [31:0] BASE [3] = '{32'h0, 32'h0, 32'h2000};
`ifdef MEM_FAULT_EN
   localparam bit FAULT_EN = 1'b1;
`else
   localparam bit FAULT_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] rdata;
      bit          chk_rdata;
      bit          fault;
   } exp_t;

   logic        clk;
   logic        rst [3];
   logic        rdy [3];
   logic        ins [3];
   logic [31:0] adr [3];
   logic [3:0]  ws  [3];
   logic [31:0] wd  [3];
   logic        vld [3];
   logic [31:0] rd  [3];
   logic        flt [3];

   logic [31:0] model_mem   [3][NW];
   bit          model_known [3][NW];
   exp_t        sb [$];

   int checks   = 0;
   int failures = 0;

   mem_responder_if if0 ();
   mem_responder_if if1 ();
   mem_responder_if if2 ();

   assign if0.mem_ready = rdy[0]; assign if0.mem_instr = ins[0]; assign if0.mem_addr = adr[0];
   assign if0.mem_wstrb = ws[0];  assign if0.mem_wdata = wd[0];
   assign if1.mem_ready = rdy[1]; assign if1.mem_instr = ins[1]; assign if1.mem_addr = adr[1];
   assign if1.mem_wstrb = ws[1];  assign if1.mem_wdata = wd[1];
   assign if2.mem_ready = rdy[2]; assign if2.mem_instr = ins[2]; assign if2.mem_addr = adr[2];
   assign if2.mem_wstrb = ws[2];  assign if2.mem_wdata = wd[2];
   assign vld[0] = if0.mem_valid; assign rd[0] = if0.mem_rdata;
   assign vld[1] = if1.mem_valid; assign rd[1] = if1.mem_rdata;
   assign vld[2] = if2.mem_valid; assign rd[2] = if2.mem_rdata;
`ifdef MEM_FAULT_EN
   assign flt[0] = if0.mem_fault; assign flt[1] = if1.mem_fault; assign flt[2] = if2.mem_fault;
`else
   assign flt[0] = 1'b0; assign flt[1] = 1'b0; assign flt[2] = 1'b0;
`endif

   mem_responder #(.DEPTH(NW), .LATENCY(1), .BASE_ADDR(32'h0))
      u_dut0 (.clk(clk), .reset(rst[0]), .mem_if(if0));
   mem_responder #(.DEPTH(NW), .LATENCY(3), .BASE_ADDR(32'h0))
      u_dut1 (.clk(clk), .reset(rst[1]), .mem_if(if1));
   mem_responder #(.DEPTH(NW), .LATENCY(4), .BASE_ADDR(32'h2000))
      u_dut2 (.clk(clk), .reset(rst[2]), .mem_if(if2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference behaviour of one access: returns the expected response and updates the model.
   function automatic exp_t model_access(input int k, input bit instr, input logic [31:0] addr,
                                         input logic [3:0] wstrb, input logic [31:0] wdata);
      exp_t   e;
      longint off;
      bit     inr;
      int     idx;
      bit     f;
      off = longint'(addr) - longint'(BASE[k]);
      inr = (off >= 0) && ((off >>> 2) < NW);
      idx = inr ? int'(off >>> 2) : 0;
      f   = !inr || ((addr[1:0] != 2'b00) && (wstrb == 4'hF || instr)) || (instr && wstrb != 4'h0);
      e.rdata     = inr ? model_mem[k][idx] : 32'h0;
      e.chk_rdata = !inr || model_known[k][idx];
      e.fault     = FAULT_EN && f;
      if (inr && !instr && !(FAULT_EN && f)) begin
         for (int b = 0; b < 4; b++)
            if (wstrb[b]) model_mem[k][idx][b*8 +: 8] = wdata[b*8 +: 8];
         model_known[k][idx] = model_known[k][idx] || (wstrb == 4'hF);
      end
      return e;
   endfunction

   task automatic drive(input int k, input bit instr, input logic [31:0] addr,
                        input logic [3:0] wstrb, input logic [31:0] wdata);
      rdy[k] = 1'b1; ins[k] = instr; adr[k] = addr; ws[k] = wstrb; wd[k] = wdata;
   endtask

   task automatic compare_resp(input int k, input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         check({tag, "_unexpected_valid"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         if (e.chk_rdata) check({tag, "_rdata"}, rd[k], e.rdata);
`ifdef MEM_FAULT_EN
         check({tag, "_fault"}, {31'b0, flt[k]}, {31'b0, e.fault});
`endif
      end
   endtask

   // One complete transaction on instance k: accept, latency, data, single-cycle pulse.
   task automatic xfer(input string tag, input int k, input bit instr, input logic [31:0] addr,
                       input logic [3:0] wstrb, input logic [31:0] wdata);
      int cyc;
      bit got;
      sb.push_back(model_access(k, instr, addr, wstrb, wdata));
      @(negedge clk);
      drive(k, instr, addr, wstrb, wdata);
      @(posedge clk);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (vld[k]) got = 1'b1;
      end
      check({tag, "_latency"}, cyc, LAT[k]);
      if (got) compare_resp(k, tag);
      else void'(sb.pop_front());
      rdy[k] = 1'b0;
      @(negedge clk);
      check({tag, "_pulse"}, {31'b0, vld[k]}, 32'd0);
      $display("txn %s k=%0d instr=%0d addr=%h wstrb=%b rdata=%h lat=%0d", tag, k, instr, addr,
               wstrb, rd[k], cyc);
   endtask

   initial begin
      int   pulses, first_c, second_c;
      exp_t dropped;

      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1; rdy[k] = 1'b0; ins[k] = 1'b0; adr[k] = '0; ws[k] = '0; wd[k] = '0;
         for (int i = 0; i < NW; i++) begin
            model_mem[k][i]   = 32'h0;
            model_known[k][i] = 1'b0;
         end
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset_valid%0d", k), {31'b0, vld[k]}, 32'd0);
         check($sformatf("reset_rdata%0d", k), rd[k], 32'h0);
`ifdef MEM_FAULT_EN
         check($sformatf("reset_fault%0d", k), {31'b0, flt[k]}, 32'd0);
`endif
         rst[k] = 1'b0;
      end
      @(negedge clk);

      xfer("wr_word",    0, 1'b0, 32'h10,  4'b1111, 32'h11223344);
      xfer("rd_word",    0, 1'b0, 32'h10,  4'b0000, 32'h0);
      xfer("wr_byte",    0, 1'b0, 32'h12,  4'b0100, 32'hAAAAAAAA);
      xfer("rd_merged",  0, 1'b0, 32'h10,  4'b0000, 32'h0);
      xfer("wr_w0",      0, 1'b0, 32'h0,   4'b1111, 32'h01020304);
      xfer("rd_oor",     0, 1'b0, 32'h100, 4'b0000, 32'h0);
      xfer("wr_oor",     0, 1'b0, 32'h100, 4'b1111, 32'hDEADBEEF);
      xfer("rd_w0",      0, 1'b0, 32'h0,   4'b0000, 32'h0);
      xfer("rd_w4",      0, 1'b0, 32'h10,  4'b0000, 32'h0);
      xfer("wr_w8",      0, 1'b0, 32'h20,  4'b1111, 32'h0BADF00D);
      xfer("fetch_wr",   0, 1'b1, 32'h20,  4'b1111, 32'hFFFFFFFF);
      xfer("rd_w8",      0, 1'b0, 32'h20,  4'b0000, 32'h0);

      // LATENCY=3 with mem_ready held: pulses expected at n+3 and n+7 only.
      xfer("l3_wr",      1, 1'b0, 32'h40,  4'b1111, 32'h5A5A0001);
      sb.push_back(model_access(1, 1'b0, 32'h40, 4'b0000, 32'h0));
      sb.push_back(model_access(1, 1'b0, 32'h40, 4'b0000, 32'h0));
      @(negedge clk);
      drive(1, 1'b0, 32'h40, 4'b0000, 32'h0);
      @(posedge clk);
      pulses = 0; first_c = 0; second_c = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (vld[1]) begin
            pulses++;
            if (first_c == 0) first_c = c;
            else second_c = c;
            compare_resp(1, "b2b");
         end
         if (c == 7) rdy[1] = 1'b0;
      end
      check("b2b_first_cycle",  first_c,  32'd3);
      check("b2b_second_cycle", second_c, 32'd7);
      check("b2b_pulse_count",  pulses,   32'd2);
      $display("txn b2b k=1 pulses=%0d first=%0d second=%0d", pulses, first_c, second_c);

      // LATENCY=4: reset during WAIT aborts the response but keeps the write.
      xfer("l4_wr",      2, 1'b0, 32'h2030, 4'b1111, 32'h12345678);
      dropped = model_access(2, 1'b0, 32'h2030, 4'b1111, 32'hCAFEF00D);
      @(negedge clk);
      drive(2, 1'b0, 32'h2030, 4'b1111, 32'hCAFEF00D);
      @(posedge clk);
      @(negedge clk);
      rst[2] = 1'b1;
      rdy[2] = 1'b0;
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         rst[2] = 1'b0;
         if (vld[2]) pulses++;
      end
      check("abort_no_valid", pulses, 32'd0);
      $display("txn abort k=2 addr=00002030 pulses=%0d old=%h", pulses, dropped.rdata);
      xfer("l4_rd_after", 2, 1'b0, 32'h2030, 4'b0000, 32'h0);
      xfer("l4_rd_below", 2, 1'b0, 32'h1FFC, 4'b0000, 32'h0);

      check("scoreboard_empty", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
